// File: rtl/fifo_byte_serializer.sv
// Drains WIDTH-bit words from the upstream FIFO and emits them as a valid/ready byte stream,
// with back-to-back word chaining and a wrapping completed-word counter.
module fifo_byte_serializer #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0,
    parameter int COUNT_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   fifo_data_i,
    input  logic               fifo_pnding_i,
    output logic               fifo_pop_o,
    output logic [7:0]         data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               last_o,
    output logic               busy_o,
    output logic [COUNT_W-1:0] words_o
);
    localparam int NBYTES = WIDTH / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] IDX_PEN  = IDX_W'(NBYTES - 2);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   word_q, word_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [7:0]         data_nxt;
    logic               valid_nxt, last_nxt;
    logic [COUNT_W-1:0] words_nxt;
    logic               xfer, final_xfer, load;

    function automatic logic [7:0] byte_sel(input logic [WIDTH-1:0] w, input int k);
        if (MSB_FIRST) return w[WIDTH-1-8*k -: 8];
        else           return w[8*k +: 8];
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            words_o <= '0;
        end else begin
            state   <= state_nxt;
            word_q  <= word_nxt;
            idx_q   <= idx_nxt;
            data_o  <= data_nxt;
            valid_o <= valid_nxt;
            last_o  <= last_nxt;
            words_o <= words_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        word_nxt   = word_q;
        idx_nxt    = idx_q;
        data_nxt   = data_o;
        valid_nxt  = valid_o;
        last_nxt   = last_o;
        words_nxt  = words_o;

        xfer       = (state == SEND) && valid_o && ready_i;
        final_xfer = xfer && (idx_q == IDX_LAST);
        // A pop both in IDLE and on the final byte lets words chain with no idle cycle.
        load       = !rst_i && fifo_pnding_i && ((state == IDLE) || final_xfer);
        fifo_pop_o = load;

        if (final_xfer) begin
            words_nxt = words_o + 1'b1;
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
        end else if (xfer) begin
            idx_nxt  = idx_q + 1'b1;
            data_nxt = byte_sel(word_q, int'(idx_q) + 1);
            last_nxt = (idx_q == IDX_PEN);
        end

        if (load) begin
            state_nxt = SEND;
            word_nxt  = fifo_data_i;
            idx_nxt   = '0;
            data_nxt  = byte_sel(fifo_data_i, 0);
            valid_nxt = 1'b1;
            last_nxt  = 1'b0;
        end
    end

    assign busy_o = (state == SEND);
endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Bench for fifo_byte_serializer: a word-level model (held word + byte index) checked every
// cycle against an LSB-first/8-bit-count DUT and an MSB-first/2-bit-count DUT fed identically.
module tb_fifo_byte_serializer;
    localparam int NB = 4;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ready, fifo_en, pnd;
    logic [31:0] fdata;
    logic        pop_a, valid_a, last_a, busy_a;
    logic [7:0]  data_a, words_a;
    logic        pop_b, valid_b, last_b, busy_b;
    logic [7:0]  data_b;
    logic [1:0]  words_b;

    logic [31:0] fq[$];
    int          qn;
    logic [31:0] qhead;

    assign pnd   = fifo_en && (qn > 0);
    assign fdata = qhead;

    fifo_byte_serializer #(.WIDTH(32), .MSB_FIRST(1'b0), .COUNT_W(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .fifo_data_i(fdata), .fifo_pnding_i(pnd), .fifo_pop_o(pop_a),
        .data_o(data_a), .valid_o(valid_a), .ready_i(ready), .last_o(last_a), .busy_o(busy_a),
        .words_o(words_a));

    fifo_byte_serializer #(.WIDTH(32), .MSB_FIRST(1'b1), .COUNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .fifo_data_i(fdata), .fifo_pnding_i(pnd), .fifo_pop_o(pop_b),
        .data_o(data_b), .valid_o(valid_b), .ready_i(ready), .last_o(last_b), .busy_o(busy_b),
        .words_o(words_b));

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic refresh();
        qn    = fq.size();
        qhead = (qn > 0) ? fq[0] : 32'h0;
    endtask

    // Word-level model: is a word held, which byte of it is presented, how many words done.
    bit          m_hold, m_fresh;
    int          m_k, m_cnt;
    logic [31:0] m_w;

    function automatic logic exp_pop();
        return !rst && pnd && (!m_hold || (m_k == NB - 1 && ready));
    endfunction

    function automatic logic [7:0] bsel(input logic [31:0] w, input int k, input bit msb);
        int sh;
        sh = msb ? 8 * (NB - 1 - k) : 8 * k;
        return 8'(w >> sh);
    endfunction

    initial begin
        bit p;
        m_hold = 0; m_fresh = 1; m_k = 0; m_cnt = 0; m_w = '0;
        refresh();
        forever begin
            @(posedge clk);
            p = exp_pop();
            if (rst) begin
                m_hold = 0; m_k = 0; m_cnt = 0; m_fresh = 1;
            end else begin
                if (m_hold && ready) begin
                    if (m_k == NB - 1) begin
                        m_cnt++;
                        m_hold = 0;
                    end else m_k++;
                end
                if (p) begin
                    m_w = fq.pop_front();
                    m_hold = 1; m_k = 0; m_fresh = 0;
                end
            end
            #1 refresh();
        end
    end

    // Per-cycle compare plus logs of accepted bytes for the literal checks.
    bq_t         log_a, log_b, wlog;
    int          tcyc[$];
    int          cyc_n = 0, npops = 0;
    logic [7:0]  pop_with = '0;
    bit          wpend = 0;

    initial begin
        logic e_pop;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc_n++;
            e_pop = exp_pop();
            chk("pop_a", 64'(pop_a), 64'(e_pop));
            chk("pop_b", 64'(pop_b), 64'(e_pop));
            chk("valid_a", 64'(valid_a), 64'(m_hold));
            chk("valid_b", 64'(valid_b), 64'(m_hold));
            chk("last_a", 64'(last_a), 64'(m_hold && m_k == NB - 1));
            chk("last_b", 64'(last_b), 64'(m_hold && m_k == NB - 1));
            chk("busy_a", 64'(busy_a), 64'(m_hold));
            chk("busy_b", 64'(busy_b), 64'(m_hold));
            chk("words_a", 64'(words_a), 64'(m_cnt % 256));
            chk("words_b", 64'(words_b), 64'(m_cnt % 4));
            if (m_hold) begin
                chk("data_a", 64'(data_a), 64'(bsel(m_w, m_k, 1'b0)));
                chk("data_b", 64'(data_b), 64'(bsel(m_w, m_k, 1'b1)));
            end else if (m_fresh) begin
                chk("data_a_rst", 64'(data_a), 64'h0);
                chk("data_b_rst", 64'(data_b), 64'h0);
            end
            if (wpend) wlog.push_back(8'(words_b));
            wpend = !rst && valid_a && ready && last_a;
            if (!rst && valid_a && ready) begin
                log_a.push_back(data_a);
                log_b.push_back(data_b);
                tcyc.push_back(cyc_n);
            end
            if (pop_a) begin
                npops++;
                if (valid_a) pop_with = data_a;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clr_logs();
        log_a.delete(); log_b.delete(); wlog.delete(); tcyc.delete();
        npops = 0; pop_with = '0;
    endtask

    // Expected byte i is exp[8*(n-1-i) +: 8], i.e. the literal reads in stream order.
    task automatic chk_bytes(input string nm, input bq_t got, input int n, input logic [63:0] exp);
        chk({nm, "_len"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < n && i < got.size(); i++)
            chk(nm, 64'(got[i]), 64'(exp[8*(n-1-i) +: 8]));
    endtask

    initial begin
        rst = 1; ready = 1; fifo_en = 1;
        fq.push_back(32'hA1B2C3D4);
        refresh();

        // Reset held two edges with a word pending: no pop, outputs cleared.
        cyc(2);
        chk("t1_pop", 64'(pop_a), 64'h0);
        chk("t1_valid", 64'(valid_a), 64'h0);
        chk("t1_data", 64'(data_a), 64'h0);

        // Single word, ready high.
        clr_logs();
        rst = 0;
        #1 chk("t2_pop_now", 64'(pop_a), 64'h1);
        cyc(6);
        chk_bytes("t2_lsb", log_a, 4, 64'hD4C3B2A1);
        chk_bytes("t2_msb", log_b, 4, 64'hA1B2C3D4);
        chk("t2_pops", 64'(npops), 64'd1);
        chk("t2_valid_end", 64'(valid_a), 64'h0);
        chk("t2_words", 64'(words_a), 64'd1);

        // Backpressure while C3 is presented.
        clr_logs();
        fq.push_back(32'hA1B2C3D4); refresh();
        for (int i = 0; i < 20 && !(valid_a && data_a == 8'hC3); i++) cyc(1);
        chk("t3_reach_c3", 64'(valid_a && data_a == 8'hC3), 64'h1);
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t3_hold_data", 64'(data_a), 64'hC3);
            chk("t3_hold_valid", 64'(valid_a), 64'h1);
        end
        ready = 1;
        cyc(4);
        chk_bytes("t3_lsb", log_a, 4, 64'hD4C3B2A1);
        chk("t3_words", 64'(words_a), 64'd2);

        // Back-to-back words.
        rst = 1; cyc(1); rst = 0;
        clr_logs();
        fifo_en = 0;
        fq.push_back(32'h11223344); fq.push_back(32'h55667788); refresh();
        cyc(1);
        fifo_en = 1;
        cyc(10);
        chk_bytes("t4_lsb", log_a, 8, 64'h4433221188776655);
        chk_bytes("t4_msb", log_b, 8, 64'h1122334455667788);
        if (tcyc.size() == 8) chk("t4_nogap", 64'(tcyc[7] - tcyc[0]), 64'd7);
        else chk("t4_tcyc_len", 64'(tcyc.size()), 64'd8);
        chk("t4_pop_at_11", 64'(pop_with), 64'h11);
        chk("t4_pops", 64'(npops), 64'd2);
        chk("t4_words", 64'(words_a), 64'd2);

        // Reset after two bytes accepted; the held word is dropped.
        clr_logs();
        fq.push_back(32'hA1B2C3D4); refresh();
        for (int i = 0; i < 20 && log_a.size() < 2; i++) cyc(1);
        chk("t5_two_bytes", 64'(log_a.size()), 64'd2);
        rst = 1;
        fq.push_back(32'h0F1E2D3C); refresh();
        cyc(1);
        chk("t5_valid", 64'(valid_a), 64'h0);
        chk("t5_words", 64'(words_a), 64'h0);
        chk("t5_len_rst", 64'(log_a.size()), 64'd2);
        rst = 0;
        #1 chk("t5_repop", 64'(pop_a), 64'h1);
        cyc(6);
        chk_bytes("t5_lsb", log_a, 6, 64'hD4C33C2D1E0F);
        chk("t5_pops", 64'(npops), 64'd2);
        chk("t5_words_end", 64'(words_a), 64'd1);

        // Five words through the 2-bit counter.
        rst = 1; cyc(1); rst = 0;
        clr_logs();
        for (int i = 0; i < 5; i++) fq.push_back(32'h01020304 + 32'(i) * 32'h10101010);
        refresh();
        cyc(25);
        chk_bytes("t6_wrap", wlog, 5, 64'h0102030001);
        chk("t6_words_a", 64'(words_a), 64'd5);
        chk("t6_first_msb", 64'(log_b.size() > 0 ? log_b[0] : 8'h00), 64'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
